prog_loader: RTL

Boot-time program loader upstream of the single-cycle CPU's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory through a write port. Holds the CPU in reset until a length-prefixed, checksummed image has loaded correctly. On a malformed image, it latches an error and keeps the CPU in reset.

---
 rtl/prog_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time loader: byte stream to instruction memory with length and XOR checksum
module prog_loader #(
  parameter int ADDR_W = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  // Loader states; DONE and ERR are terminal until reset.
  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  // Largest acceptable word count; 17 bits so 2**16 cannot alias.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  logic [2:0]        state;
  logic [15:0]       count;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;
  logic [7:0]        csum;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;

  logic              accepting;
  logic              fire;
  logic [16:0]       hdr_count;
  logic [15:0]       words_done;
  logic [31:0]       word_next;
  logic [31:0]       word_addr;
  logic [7:0]        csum_next;

  // Ready is gated by reset so nothing is accepted in the reset cycle.
  assign accepting = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                     (state == S_DATA)   || (state == S_CSUM);
  assign byte_ready_o = accepting & ~rst_i;
  assign fire = byte_valid_i & byte_ready_o;

  // Full count as it will be once the low header byte lands.
  assign hdr_count  = {1'b0, count[15:8], byte_data_i};
  // Words completed including the one finishing this cycle; wider than the
  // index so a full-capacity image does not wrap before the compare.
  assign words_done = 16'(word_idx) + 16'd1;
  assign word_next  = {asm_q, byte_data_i};
  assign word_addr  = {{(30 - ADDR_W){1'b0}}, word_idx, 2'b00};
  assign csum_next  = csum ^ byte_data_i;

  // State sequencing: header parse, data phase, checksum verdict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_HDR_HI;
    end else if (fire) begin
      case (state)
        S_HDR_HI: state <= S_HDR_LO;
        S_HDR_LO: begin
          if (hdr_count > CAPACITY) begin
            state <= S_ERR;
          end else if (hdr_count == 17'd0) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (byte_idx == 2'd3 && words_done == count) begin
            state <= S_CSUM;
          end
        end
        S_CSUM: state <= (byte_data_i == csum) ? S_DONE : S_ERR;
        default: state <= state;
      endcase
    end
  end

  // Header count, word/byte indices, assembly register and running XOR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count    <= 16'd0;
      word_idx <= '0;
      byte_idx <= 2'd0;
      asm_q    <= 24'd0;
      csum     <= 8'd0;
    end else if (fire) begin
      case (state)
        S_HDR_HI: count[15:8] <= byte_data_i;
        S_HDR_LO: begin
          count[7:0] <= byte_data_i;
          word_idx   <= '0;
          byte_idx   <= 2'd0;
          csum       <= 8'd0;
        end
        S_DATA: begin
          asm_q    <= word_next[23:0];
          csum     <= csum_next;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            word_idx <= word_idx + 1'b1;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  // Registered write port: one-cycle strobe, address/data held until next word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else begin
      we_q <= 1'b0;
      if (fire && state == S_DATA && byte_idx == 2'd3) begin
        we_q   <= 1'b1;
        addr_q <= word_addr;
        data_q <= word_next;
      end
    end
  end

  // Outputs forced to reset values during the reset cycle itself, which also
  // kills a strobe for a word whose last byte landed just before reset.
  assign im_we_o   = we_q & ~rst_i;
  assign im_addr_o = rst_i ? 32'd0 : addr_q;
  assign im_data_o = rst_i ? 32'd0 : data_q;
  assign done_o    = ~rst_i & (state == S_DONE);
  assign err_o     = ~rst_i & (state == S_ERR);
  assign cpu_rst_o = rst_i | (state != S_DONE);

endmodule
